// File: rtl/lr35902_intc_if.sv
// Bus and CPU-side signal bundle for the LR35902 interrupt controller.
// The slave modport is the controller; the master modport is the bus/CPU side.
interface lr35902_intc_if #(
  parameter int unsigned NUM_IRQ = 5
);
  logic [7:0]         dout;
  logic [7:0]         din;
  logic               adr;
  logic               read;
  logic               write;
  logic [NUM_IRQ-1:0] irq_in;
  logic               int_req;
  logic [7:0]         int_vec;
  logic               int_ack;

  modport master (
    input  dout, int_req, int_vec,
    output din, adr, read, write, irq_in, int_ack
  );

  modport slave (
    output dout, int_req, int_vec,
    input  din, adr, read, write, irq_in, int_ack
  );
endinterface

// File: rtl/lr35902_intc.sv
// LR35902 interrupt controller: IF/IE registers on the strobe bus, and a
// lowest-index-first request/vector to the CPU with flag clear on acknowledge.
module lr35902_intc #(
  parameter int unsigned NUM_IRQ  = 5,
  parameter logic [7:0]  VEC_BASE = 8'h40
) (
  input logic            clk,
  input logic            reset,
  lr35902_intc_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] if_q, if_nxt;
  logic [7:0]         ie_q, ie_nxt;
  logic [7:0]         dout_q;
  logic               wr_pend;
  logic               r_adr;
  logic [7:0]         r_din;
  logic               read_d;
  logic               write_d;

  logic [NUM_IRQ-1:0] pend;
  logic [IDX_W-1:0]   idx;

  assign pend = if_q & ie_q[NUM_IRQ-1:0];

  // Scan high to low so the lowest pending index wins.
  always_comb begin
    idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend[i]) idx = IDX_W'(i);
    end
  end

  assign bus.int_req = |pend;
  assign bus.int_vec = VEC_BASE + 8'({idx, 3'b000});
  assign bus.dout    = dout_q;

  // Write lands first, then the ack clears, then new requests OR in on top.
  always_comb begin
    if_nxt = if_q;
    ie_nxt = ie_q;
    if (wr_pend) begin
      if (r_adr) ie_nxt = r_din;
      else       if_nxt = r_din[NUM_IRQ-1:0];
    end
    if (bus.int_ack && (|pend)) if_nxt[idx] = 1'b0;
    if_nxt = if_nxt | bus.irq_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_q    <= '0;
      ie_q    <= '0;
      dout_q  <= '0;
      wr_pend <= 1'b0;
      r_adr   <= 1'b0;
      r_din   <= '0;
      read_d  <= 1'b0;
      write_d <= 1'b0;
    end else begin
      read_d  <= bus.read;
      write_d <= bus.write;
      if_q    <= if_nxt;
      ie_q    <= ie_nxt;
      if (bus.read && !read_d) begin
        dout_q <= bus.adr ? ie_q : {{(8 - NUM_IRQ){1'b1}}, if_q};
      end
      // Capture on the write falling edge; commit one edge later.
      if (write_d && !bus.write) begin
        r_adr   <= bus.adr;
        r_din   <= bus.din;
        wr_pend <= 1'b1;
      end else begin
        wr_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lr35902_intc.sv
// Bench for lr35902_intc: directed vector table, a reset-mid-write sequence,
// and random traffic, all checked against a transaction-level model.
module tb_lr35902_intc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  lr35902_intc_if #(.NUM_IRQ(5)) ifc ();

  lr35902_intc #(.NUM_IRQ(5), .VEC_BASE(8'h40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic       adr;
    logic [7:0] din;
    logic [4:0] irq;
    logic       ack;
    logic       chk;
    logic       exp_req;
    logic [7:0] exp_vec;
    logic       chk_dout;
    logic [7:0] exp_dout;
  } vec_t;

  typedef struct {
    logic       adr;
    logic [7:0] din;
    int         due;
  } wr_t;

  // Reference model state
  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic [7:0] m_dout;
  logic       m_prev_rd;
  logic       m_prev_wr;
  wr_t        wq[$];
  int         cyc;

  function automatic int lowest(input logic [4:0] p);
    for (int i = 0; i < 5; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_if = '0; m_ie = '0; m_dout = '0;
    m_prev_rd = 1'b0; m_prev_wr = 1'b0;
    wq.delete();
    cyc = 0;
  endtask

  task automatic model_edge(input logic rd, input logic wr, input logic adr,
                            input logic [7:0] din, input logic [4:0] irq,
                            input logic ack);
    int k;
    logic [4:0] nif;
    logic [7:0] nie;
    wr_t w;
    nif = m_if;
    nie = m_ie;
    k = lowest(m_if & m_ie[4:0]);
    if (rd && !m_prev_rd) m_dout = adr ? m_ie : {3'b111, m_if};
    while (wq.size() > 0 && wq[0].due == cyc) begin
      w = wq.pop_front();
      if (w.adr) nie = w.din;
      else       nif = w.din[4:0];
    end
    if (ack && k >= 0) nif[k] = 1'b0;
    nif = nif | irq;
    if (m_prev_wr && !wr) begin
      w.adr = adr; w.din = din; w.due = cyc + 1;
      wq.push_back(w);
    end
    m_if = nif; m_ie = nie;
    m_prev_rd = rd; m_prev_wr = wr;
    cyc++;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int k;
    logic [7:0] ev;
    k = lowest(m_if & m_ie[4:0]);
    ev = (k < 0) ? 8'h40 : 8'(64 + 8 * k);
    check8("model_int_req", {7'd0, ifc.int_req}, {7'd0, k >= 0});
    check8("model_int_vec", ifc.int_vec, ev);
    check8("model_dout", ifc.dout, m_dout);
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic step(input vec_t v, input string tag);
    ifc.read = v.rd; ifc.write = v.wr; ifc.adr = v.adr;
    ifc.din = v.din; ifc.irq_in = v.irq; ifc.int_ack = v.ack;
    @(posedge clk);
    model_edge(v.rd, v.wr, v.adr, v.din, v.irq, v.ack);
    #1;
    check_model();
    if (v.chk) begin
      check8({tag, "_int_req"}, {7'd0, ifc.int_req}, {7'd0, v.exp_req});
      check8({tag, "_int_vec"}, ifc.int_vec, v.exp_vec);
    end
    if (v.chk_dout) check8({tag, "_dout"}, ifc.dout, v.exp_dout);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic adr,
                              input logic [7:0] din, input logic [4:0] irq,
                              input logic ack, input logic chk, input logic req,
                              input logic [7:0] vec, input logic cd,
                              input logic [7:0] dout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.adr = adr; v.din = din; v.irq = irq; v.ack = ack;
    v.chk = chk; v.exp_req = req; v.exp_vec = vec; v.chk_dout = cd; v.exp_dout = dout;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t idle;

  initial begin
    ifc.read = 0; ifc.write = 0; ifc.adr = 0; ifc.din = 0; ifc.irq_in = 0; ifc.int_ack = 0;
    model_reset();
    idle = mk(0, 0, 0, 8'h00, 5'h00, 0, 0, 0, 8'h40, 0, 8'h00);

    //            rd wr adr din    irq      ack chk req vec    cd dout
    tbl.push_back(mk(1, 0, 0, 8'h00, 5'h00,   0, 1, 0, 8'h40, 1, 8'hE0)); // read IF
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00));
    tbl.push_back(mk(1, 0, 1, 8'h00, 5'h00,   0, 1, 0, 8'h40, 1, 8'h00)); // read IE
    tbl.push_back(mk(0, 1, 1, 8'h05, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h05, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00)); // fall
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   0, 1, 0, 8'h40, 0, 8'h00)); // commit IE=05
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'b00100,0, 1, 1, 8'h50, 0, 8'h00)); // timer
    tbl.push_back(mk(1, 0, 0, 8'h00, 5'h00,   0, 1, 1, 8'h50, 1, 8'hE4));
    tbl.push_back(mk(0, 1, 1, 8'h1F, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h1F, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   0, 1, 1, 8'h50, 0, 8'h00)); // IE=1F
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   1, 1, 0, 8'h40, 0, 8'h00)); // ack timer
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'b10010,0, 1, 1, 8'h48, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   1, 1, 1, 8'h60, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   1, 1, 0, 8'h40, 0, 8'h00));
    tbl.push_back(mk(1, 0, 0, 8'h00, 5'h00,   0, 1, 0, 8'h40, 1, 8'hE0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'b00001,0, 1, 1, 8'h40, 0, 8'h00)); // IF=01
    tbl.push_back(mk(0, 1, 0, 8'h00, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00)); // fall
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'b00001,0, 1, 1, 8'h40, 0, 8'h00)); // write 0 vs pulse
    tbl.push_back(mk(1, 0, 0, 8'h00, 5'h00,   0, 1, 1, 8'h40, 1, 8'hE1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'b00001,1, 1, 1, 8'h40, 0, 8'h00)); // ack vs pulse
    tbl.push_back(mk(1, 0, 0, 8'h00, 5'h00,   0, 1, 1, 8'h40, 1, 8'hE1));
    tbl.push_back(mk(0, 1, 1, 8'hA3, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00)); // hold write
    tbl.push_back(mk(0, 1, 1, 8'hA3, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00));
    tbl.push_back(mk(1, 1, 1, 8'hA3, 5'h00,   0, 0, 0, 8'h40, 1, 8'h1F)); // IE unchanged
    tbl.push_back(mk(0, 0, 1, 8'hA3, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00)); // fall
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   0, 1, 1, 8'h40, 0, 8'h00)); // commit
    tbl.push_back(mk(1, 0, 1, 8'h00, 5'h00,   0, 1, 1, 8'h40, 1, 8'hA3));
    tbl.push_back(mk(0, 0, 0, 8'h00, 5'h00,   0, 0, 0, 8'h40, 0, 8'h00));

    repeat (2) @(posedge clk);
    #1;
    check8("reset_int_req", {7'd0, ifc.int_req}, 8'h00);
    check8("reset_int_vec", ifc.int_vec, 8'h40);
    check8("reset_dout", ifc.dout, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Reset while a captured write waits to commit: the write must be lost.
    step(mk(0, 1, 1, 8'h5C, 5'h00, 0, 0, 0, 8'h40, 0, 8'h00), "rst_wr_hi");
    step(mk(0, 0, 1, 8'h5C, 5'h00, 0, 0, 0, 8'h40, 0, 8'h00), "rst_wr_fall");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check8("rst_mid_int_req", {7'd0, ifc.int_req}, 8'h00);
    check8("rst_mid_dout", ifc.dout, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    step(idle, "rst_after0");
    step(idle, "rst_after1");
    step(mk(1, 0, 1, 8'h00, 5'h00, 0, 1, 0, 8'h40, 1, 8'h00), "rst_ie_read");
    step(idle, "rst_after2");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v = idle;
      v.rd  = 1'($urandom_range(0, 2) == 0);
      v.wr  = 1'($urandom_range(0, 2) == 0);
      v.adr = 1'($urandom_range(0, 1));
      v.din = 8'($urandom);
      v.irq = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
      v.ack = 1'($urandom_range(0, 3) == 0);
      step(v, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lr35902_intc.md
Name: lr35902_intc

Overview:
- Interrupt controller for the LR35902 SoC; sits between the peripheral irq outputs (VBlank, STAT, timer, serial, joypad) and the CPU core.
- Holds the IF (flags) and IE (enable) registers on the peripheral bus.
- Uses the same edge-detected read/write strobe protocol as the other peripherals.
- Presents the highest-priority pending-and-enabled request to the CPU with a vector, and clears that flag on the CPU's acknowledge.

Parameters:
- NUM_IRQ, 5, number of interrupt sources. Fixed at 5 for LR35902; other values are unsupported.
- VEC_BASE, 8'h40, vector address of source 0; source i vectors to VEC_BASE + 8*i.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- dout  output  8  bus read data
- din  input  8  bus write data
- adr  input  1  register select: 0 = IF (FF0F), 1 = IE (FFFF)
- read  input  1  bus read strobe
- write  input  1  bus write strobe
- irq_in  input  5  request pulses: bit0 VBlank, bit1 STAT, bit2 timer, bit3 serial, bit4 joypad
- int_req  output  1  at least one IF&IE bit set (also serves as HALT wake)
- int_vec  output  8  vector of the highest-priority pending-and-enabled source
- int_ack  input  1  one-cycle CPU acknowledge; clears the flag named by int_vec in that cycle

Behaviour:
- Reset (asynchronous):
  - State cleared: IF = 5'h00, IE = 8'h00, dout = 8'h00, pending-write flag = 0, strobe history = 0.
  - Outputs: int_req = 0, int_vec = VEC_BASE.
- Registers:
  - IF is 5 bits; reads back as {3'b111, IF}.
  - IE is a full 8 bits, readable and writable; only IE[4:0] gates requests.
- Read:
  - Triggered on the read rising edge (previous-cycle read = 0, current = 1).
  - dout <= selected register on that clk edge, i.e. one-cycle latency.
  - dout holds its value otherwise.
- Write:
  - Detected on the write falling edge (previous = 1, current = 0); adr and din are captured into r_adr/r_din and the pending flag is set.
  - Committed on the following clk edge, then the pending flag clears.
  - Latency: register updated 2 clk edges after write falls.
- Per-cycle update order for IF, computed combinationally and registered once:
  1. Start from current IF.
  2. Apply a pending write to IF (replaces all 5 bits).
  3. If int_ack, clear the bit selected by the pre-update int_vec.
  4. OR in irq_in.
- Net effect of the update order:
  - A new request always survives a same-cycle write or ack.
  - A write of 0 to IF cannot lose a same-cycle pulse.
- irq_in:
  - Sampled every cycle and treated as level-per-cycle set.
  - A multi-cycle high is indistinguishable from a single pulse.
- Request and priority:
  - pend = IF & IE[4:0]; int_req = |pend, combinational from registered state.
  - Priority is lowest bit index first; int_vec = VEC_BASE + {idx, 3'b000}.
  - When pend = 0, int_vec = VEC_BASE.
- Acknowledge corner cases:
  - int_ack with pend = 0: no state change.
  - int_ack and an IE write in the same cycle: the ack uses the old IE (pre-update int_vec).
- IE write takes effect on int_req the cycle after commit.
- A bus write and int_ack on IF in the same cycle follow the ordering above.
- Reset asserted mid-write discards the captured write.
- No latches; all state sits in one clocked process with async reset.

Test Plan:
- Reset, then read IF and IE -> dout = 8'hE0 then 8'h00; int_req = 0.
- Write IE = 8'h05; pulse irq_in = 5'b00100 -> IF = 5'h04; int_req = 1 on the next cycle; int_vec = 8'h50.
- IE = 8'h1F; pulse irq_in = 5'b10010 -> int_vec = 8'h48; int_ack -> IF = 5'h10, int_vec = 8'h60; int_ack -> IF = 0, int_req = 0.
- IF = 5'h01; write IF = 8'h00 committing in the same cycle as irq_in = 5'b00001 -> IF = 5'h01 afterwards.
- int_ack on bit0 in the same cycle as an irq_in bit0 pulse -> IF[0] = 1 and int_req stays 1.
- Hold write high for 3 cycles with adr = 1, din = 8'hA3 -> IE unchanged until write falls, IE = 8'hA3 two edges later; assert reset mid-sequence -> IE = 8'h00 and no late commit.
